// File: rtl/accum_pkg.sv
// Shared types and helpers for the multi-channel accumulator.
// No logic; holds the dump-engine state encoding and a constant clog2.
// Used at elaboration time only, so it has no latency or backpressure role.
package accum_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    PRES = 2'd2
  } dump_state_t;

  // Ceiling log2 for sizing channel and shift fields; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/accum_sat_addsub.sv
// Combinational AW-bit add/subtract with saturate-or-wrap result select.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the caller decides whether the result is committed.
module accum_sat_addsub #(
  parameter int AW = 16
)(
  input  logic [AW-1:0] a,
  input  logic [AW-1:0] b,
  input  logic          sub,
  input  logic          sat,
  output logic [AW-1:0] y,
  output logic          ovf
);

  logic [AW:0] raw;

  // One extra bit captures carry-out on add or borrow on subtract; a
  // saturating result clamps toward the rail the operation was heading for.
  always_comb begin
    raw = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    ovf = raw[AW];
    y   = raw[AW-1:0];
    if (sat && raw[AW]) begin
      y = sub ? '0 : '1;
    end
  end

endmodule

// File: rtl/accum_mc.sv
// Multi-channel accumulator with a read-and-clear dump engine per request.
// Latency: accumulate visible next cycle; dump output valid two edges after request.
// Backpressure: IN_RDY drops only during the capture cycle; dump output holds until DUMP_RDY.
module accum_mc
  import accum_pkg::*;
#(
  parameter  int DW  = 8,
  parameter  int AW  = 16,
  parameter  int NCH = 4,
  localparam int CW  = (clog2(NCH) > 1) ? clog2(NCH) : 1,
  localparam int SW  = clog2(AW) + 1
)(
  input  logic          C,
  input  logic          CLR,
  input  logic          IN_VLD,
  output logic          IN_RDY,
  input  logic [CW-1:0] IN_CH,
  input  logic [DW-1:0] IN_D,
  input  logic          IN_SUB,
  input  logic          MODE_SAT,
  input  logic          DUMP_REQ,
  input  logic [CW-1:0] DUMP_CH,
  input  logic [SW-1:0] DUMP_SHIFT,
  output logic          DUMP_BUSY,
  output logic          DUMP_VLD,
  input  logic          DUMP_RDY,
  output logic [AW-1:0] DUMP_Q,
  output logic          DUMP_OVF
);

  dump_state_t   state;
  dump_state_t   next_state;

  logic [AW-1:0] acc [NCH];
  logic          ovf [NCH];

  logic [CW-1:0] cap_ch;
  logic [SW-1:0] cap_shift;
  logic [AW-1:0] q_reg;
  logic          ovf_reg;

  logic          in_ch_ok;
  logic          dump_ch_ok;
  logic          acc_fire;
  logic          dump_accept;
  logic [AW-1:0] operand;
  logic [AW-1:0] sum;
  logic          sum_ovf;

  // Out-of-range channel numbers are dropped silently on both paths.
  assign in_ch_ok    = (int'(IN_CH) < NCH);
  assign dump_ch_ok  = (int'(DUMP_CH) < NCH);
  assign acc_fire    = IN_VLD && IN_RDY && in_ch_ok;
  assign dump_accept = (state == IDLE) && DUMP_REQ && dump_ch_ok;
  assign operand     = AW'(IN_D);

  accum_sat_addsub #(
    .AW (AW)
  ) u_addsub (
    .a   (acc[IN_CH]),
    .b   (operand),
    .sub (IN_SUB),
    .sat (MODE_SAT),
    .y   (sum),
    .ovf (sum_ovf)
  );

  // Dump engine state register.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Dump engine transitions and the handshake outputs derived from state.
  always_comb begin
    next_state = state;
    IN_RDY     = 1'b1;
    DUMP_BUSY  = 1'b0;
    DUMP_VLD   = 1'b0;
    DUMP_Q     = '0;
    DUMP_OVF   = 1'b0;
    case (state)
      IDLE: begin
        if (dump_accept) begin
          next_state = CAPT;
        end
      end
      CAPT: begin
        IN_RDY     = 1'b0;
        DUMP_BUSY  = 1'b1;
        next_state = PRES;
      end
      PRES: begin
        DUMP_BUSY = 1'b1;
        DUMP_VLD  = 1'b1;
        DUMP_Q    = q_reg;
        DUMP_OVF  = ovf_reg;
        if (DUMP_RDY) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Latch the dump target and shift when a request is taken.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      cap_ch    <= '0;
      cap_shift <= '0;
    end else if (dump_accept) begin
      cap_ch    <= DUMP_CH;
      cap_shift <= DUMP_SHIFT;
    end
  end

  // Snapshot the shifted accumulator and its sticky flag during capture.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      q_reg   <= '0;
      ovf_reg <= 1'b0;
    end else if (state == CAPT) begin
      q_reg   <= (int'(cap_shift) >= AW) ? '0 : (acc[cap_ch] >> cap_shift);
      ovf_reg <= ovf[cap_ch];
    end
  end

  // Per-channel accumulators; capture clears the dumped channel, and since
  // IN_RDY is low in capture the two writes never collide.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      for (int i = 0; i < NCH; i++) begin
        acc[i] <= '0;
        ovf[i] <= 1'b0;
      end
    end else begin
      if (state == CAPT) begin
        acc[cap_ch] <= '0;
        ovf[cap_ch] <= 1'b0;
      end
      if (acc_fire) begin
        acc[IN_CH] <= sum;
        ovf[IN_CH] <= ovf[IN_CH] | sum_ovf;
      end
    end
  end

endmodule

// File: tb/tb_accum_mc.sv
// Directed self-checking bench for accum_mc at DW=8, AW=16, NCH=4.
// Stimulus is driven on the falling edge and outputs are sampled there too.
// Each check is an immediate assertion that counts and reports failures.
module tb_accum_mc;

  logic        C;
  logic        CLR;
  logic        IN_VLD;
  logic        IN_RDY;
  logic [1:0]  IN_CH;
  logic [7:0]  IN_D;
  logic        IN_SUB;
  logic        MODE_SAT;
  logic        DUMP_REQ;
  logic [1:0]  DUMP_CH;
  logic [4:0]  DUMP_SHIFT;
  logic        DUMP_BUSY;
  logic        DUMP_VLD;
  logic        DUMP_RDY;
  logic [15:0] DUMP_Q;
  logic        DUMP_OVF;

  int checks = 0;
  int errors = 0;
  int q;
  int ov;

  accum_mc #(.DW(8), .AW(16), .NCH(4)) dut (
    .C          (C),
    .CLR        (CLR),
    .IN_VLD     (IN_VLD),
    .IN_RDY     (IN_RDY),
    .IN_CH      (IN_CH),
    .IN_D       (IN_D),
    .IN_SUB     (IN_SUB),
    .MODE_SAT   (MODE_SAT),
    .DUMP_REQ   (DUMP_REQ),
    .DUMP_CH    (DUMP_CH),
    .DUMP_SHIFT (DUMP_SHIFT),
    .DUMP_BUSY  (DUMP_BUSY),
    .DUMP_VLD   (DUMP_VLD),
    .DUMP_RDY   (DUMP_RDY),
    .DUMP_Q     (DUMP_Q),
    .DUMP_OVF   (DUMP_OVF)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Holds one accumulate request for n rising edges.
  task automatic acc_op(input int ch, input int d, input bit sub, input bit sat, input int n);
    @(negedge C);
    IN_VLD   = 1'b1;
    IN_CH    = 2'(ch);
    IN_D     = 8'(d);
    IN_SUB   = sub;
    MODE_SAT = sat;
    repeat (n) @(negedge C);
    IN_VLD   = 1'b0;
  endtask

  // Full dump with the consumer always ready; returns the presented value.
  task automatic dump(input int ch, input int sh, output int dq, output int dovf);
    bit got;
    got  = 1'b0;
    dq   = -1;
    dovf = -1;
    @(negedge C);
    DUMP_REQ   = 1'b1;
    DUMP_CH    = 2'(ch);
    DUMP_SHIFT = 5'(sh);
    DUMP_RDY   = 1'b1;
    @(negedge C);
    DUMP_REQ   = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge C);
      if (DUMP_VLD) begin
        got  = 1'b1;
        dq   = int'(DUMP_Q);
        dovf = int'(DUMP_OVF);
      end
    end
    chk("dump_vld_seen", 32'(got), 32'd1);
    @(negedge C);
    DUMP_RDY = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    CLR = 1'b1; IN_VLD = 0; IN_CH = 0; IN_D = 0; IN_SUB = 0; MODE_SAT = 0;
    DUMP_REQ = 0; DUMP_CH = 0; DUMP_SHIFT = 0; DUMP_RDY = 0;
    #12;
    chk("rst_in_rdy", 32'(IN_RDY), 32'd1);
    chk("rst_vld", 32'(DUMP_VLD), 32'd0);
    chk("rst_busy", 32'(DUMP_BUSY), 32'd0);
    chk("rst_q", 32'(DUMP_Q), 32'd0);
    chk("rst_ovf", 32'(DUMP_OVF), 32'd0);
    @(negedge C);
    CLR = 1'b0;

    // 200 x 3 on ch1, then read-and-clear
    acc_op(1, 200, 0, 0, 3);
    dump(1, 0, q, ov);
    chk("ch1_sum_q", 32'(q), 32'd600);
    chk("ch1_sum_ovf", 32'(ov), 32'd0);
    dump(1, 0, q, ov);
    chk("ch1_cleared", 32'(q), 32'd0);

    // ch0 = 65500 then +100 saturating
    acc_op(0, 255, 0, 0, 256);
    acc_op(0, 220, 0, 0, 1);
    acc_op(0, 100, 0, 1, 1);
    dump(0, 0, q, ov);
    chk("sat_add_q", 32'(q), 32'd65535);
    chk("sat_add_ovf", 32'(ov), 32'd1);

    // same stimulus wrapping
    acc_op(0, 255, 0, 0, 256);
    acc_op(0, 220, 0, 0, 1);
    acc_op(0, 100, 0, 0, 1);
    dump(0, 0, q, ov);
    chk("wrap_add_q", 32'(q), 32'd64);
    chk("wrap_add_ovf", 32'(ov), 32'd1);

    // ch2 = 5 minus 9, saturating then wrapping
    acc_op(2, 5, 0, 0, 1);
    acc_op(2, 9, 1, 1, 1);
    dump(2, 0, q, ov);
    chk("sat_sub_q", 32'(q), 32'd0);
    chk("sat_sub_ovf", 32'(ov), 32'd1);
    acc_op(2, 5, 0, 0, 1);
    acc_op(2, 9, 1, 0, 1);
    dump(2, 0, q, ov);
    chk("wrap_sub_q", 32'(q), 32'd65532);
    chk("wrap_sub_ovf", 32'(ov), 32'd1);
    dump(2, 0, q, ov);
    chk("ovf_cleared", 32'(ov), 32'd0);

    // ch3 = 1000, dump shift 2 with consumer stalled
    acc_op(3, 250, 0, 0, 4);
    @(negedge C);
    DUMP_REQ = 1'b1; DUMP_CH = 2'd3; DUMP_SHIFT = 5'd2; DUMP_RDY = 1'b0;
    @(negedge C);
    chk("capt_in_rdy", 32'(IN_RDY), 32'd0);
    chk("capt_busy", 32'(DUMP_BUSY), 32'd1);
    chk("capt_vld", 32'(DUMP_VLD), 32'd0);
    chk("capt_q", 32'(DUMP_Q), 32'd0);
    DUMP_CH = 2'd1; DUMP_SHIFT = 5'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge C);
      chk("pres_vld", 32'(DUMP_VLD), 32'd1);
      chk("pres_q", 32'(DUMP_Q), 32'd250);
      chk("pres_ovf", 32'(DUMP_OVF), 32'd0);
      chk("pres_in_rdy", 32'(IN_RDY), 32'd1);
      chk("pres_busy", 32'(DUMP_BUSY), 32'd1);
      if (i == 0) begin
        IN_VLD = 1'b1; IN_CH = 2'd1; IN_D = 8'd3; IN_SUB = 1'b0; MODE_SAT = 1'b0;
      end else begin
        IN_VLD = 1'b0;
      end
    end
    DUMP_REQ = 1'b0;
    DUMP_RDY = 1'b1;
    @(negedge C);
    DUMP_RDY = 1'b0;
    chk("done_vld", 32'(DUMP_VLD), 32'd0);
    chk("done_q", 32'(DUMP_Q), 32'd0);
    chk("done_busy", 32'(DUMP_BUSY), 32'd0);
    dump(1, 0, q, ov);
    chk("pres_acc_ch1", 32'(q), 32'd3);
    dump(3, 0, q, ov);
    chk("ch3_cleared", 32'(q), 32'd0);

    // shift at or beyond AW yields 0 and still clears
    acc_op(3, 50, 0, 0, 1);
    dump(3, 16, q, ov);
    chk("big_shift_q", 32'(q), 32'd0);
    dump(3, 0, q, ov);
    chk("big_shift_cleared", 32'(q), 32'd0);

    // same-edge request and accumulate on ch0
    acc_op(0, 10, 0, 0, 1);
    @(negedge C);
    IN_VLD = 1'b1; IN_CH = 2'd0; IN_D = 8'd7; IN_SUB = 1'b0; MODE_SAT = 1'b0;
    DUMP_REQ = 1'b1; DUMP_CH = 2'd0; DUMP_SHIFT = 5'd0; DUMP_RDY = 1'b1;
    @(negedge C);
    IN_VLD = 1'b0; DUMP_REQ = 1'b0;
    @(negedge C);
    chk("same_edge_vld", 32'(DUMP_VLD), 32'd1);
    chk("same_edge_q", 32'(DUMP_Q), 32'd17);
    @(negedge C);
    DUMP_RDY = 1'b0;

    // reset while presenting
    acc_op(2, 9, 1, 0, 1);
    acc_op(1, 4, 0, 0, 1);
    @(negedge C);
    DUMP_REQ = 1'b1; DUMP_CH = 2'd1; DUMP_SHIFT = 5'd0; DUMP_RDY = 1'b0;
    @(negedge C);
    DUMP_REQ = 1'b0;
    @(negedge C);
    chk("pre_clr_vld", 32'(DUMP_VLD), 32'd1);
    chk("pre_clr_q", 32'(DUMP_Q), 32'd4);
    #2;
    CLR = 1'b1;
    #1;
    chk("clr_vld", 32'(DUMP_VLD), 32'd0);
    chk("clr_q", 32'(DUMP_Q), 32'd0);
    chk("clr_busy", 32'(DUMP_BUSY), 32'd0);
    chk("clr_in_rdy", 32'(IN_RDY), 32'd1);
    @(negedge C);
    CLR = 1'b0;
    for (int ch = 0; ch < 4; ch++) begin
      dump(ch, 0, q, ov);
      chk("post_clr_q", 32'(q), 32'd0);
      chk("post_clr_ovf", 32'(ov), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
